// File: rtl/uart_tx_os_if.sv
// Transmit-side handshake between the TX FIFO control logic and the
// oversampled UART transmitter. The master requests frames; the slave
// serialises them and reports progress.
interface uart_tx_os_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  tx;
  logic                  tx_busy;
  logic                  tx_done;

  modport master (
    output start,
    output data_in,
    input  tx,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  start,
    input  data_in,
    output tx,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx_os.sv
// Oversampled UART transmitter. One word per accepted request is sent as
// start / DATA_WIDTH data bits (LSB first) / optional parity / stop bits.
// Every bit lasts OVERSAMPLE baud_tick pulses; with no baud_tick the line
// simply holds its current bit. All outputs come straight from flops.
module uart_tx_os #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 1,   // 0 = none, 1 = even, 2 = odd
  parameter int OVERSAMPLE = 16,  // baud_tick pulses per bit, >= 2
  parameter int STOP_BITS  = 1    // 1 or 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         baud_tick,
  uart_tx_os_if.slave  bus
);

  // Tick counter spans one bit period; bit counter covers data and stop bits.
  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = $clog2(DATA_WIDTH + STOP_BITS + 1);

  localparam logic [TW-1:0] TICK_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);
  localparam logic          ODD_PARITY = (PARITY == 2);
  localparam bit            HAS_PARITY = (PARITY != 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Parity bit for a word: even parity is the plain XOR reduction,
  // odd parity its inverse.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d,
                                      input logic                  odd);
    return (^d) ^ odd;
  endfunction

  state_t                state_r,    state_nx_s;
  logic [TW-1:0]         tick_cnt_r, tick_nx_s, tick_run_s;
  logic [BW-1:0]         bit_cnt_r,  bit_nx_s;
  logic [DATA_WIDTH-1:0] shift_r,    shift_nx_s, shift_down_s;
  logic                  par_r,      par_nx_s;
  logic                  tx_r,       tx_nx_s;
  logic                  busy_r,     busy_nx_s;
  logic                  done_r,     done_nx_s;
  logic                  bit_end_s;

  // A bit period closes on the baud_tick that finds the counter at its top.
  assign bit_end_s    = baud_tick && (tick_cnt_r == TICK_LAST);
  assign shift_down_s = shift_r >> 1'b1;

  // Tick counter advance while a frame is on the line; wraps at each bit end.
  always_comb begin
    if (!baud_tick) begin
      tick_run_s = tick_cnt_r;
    end else if (bit_end_s) begin
      tick_run_s = {TW{1'b0}};
    end else begin
      tick_run_s = tick_cnt_r + 1'b1;
    end
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_nx_s = state_r;
    tick_nx_s  = tick_cnt_r;
    bit_nx_s   = bit_cnt_r;
    shift_nx_s = shift_r;
    par_nx_s   = par_r;
    tx_nx_s    = tx_r;
    busy_nx_s  = busy_r;
    done_nx_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        tx_nx_s   = 1'b1;
        busy_nx_s = 1'b0;
        if (bus.start) begin
          // Accept: a baud_tick on this same edge is deliberately not counted.
          shift_nx_s = bus.data_in;
          par_nx_s   = parity_bit(bus.data_in, ODD_PARITY);
          tick_nx_s  = {TW{1'b0}};
          bit_nx_s   = {BW{1'b0}};
          tx_nx_s    = 1'b0;
          busy_nx_s  = 1'b1;
          state_nx_s = ST_START;
        end else begin
          tick_nx_s = tick_cnt_r;
        end
      end

      ST_START: begin
        tick_nx_s = tick_run_s;
        if (bit_end_s) begin
          tx_nx_s    = shift_r[0];
          bit_nx_s   = {BW{1'b0}};
          state_nx_s = ST_DATA;
        end else begin
          tx_nx_s = 1'b0;
        end
      end

      ST_DATA: begin
        tick_nx_s = tick_run_s;
        if (bit_end_s) begin
          shift_nx_s = shift_down_s;
          if (bit_cnt_r == DATA_LAST) begin
            bit_nx_s = {BW{1'b0}};
            if (HAS_PARITY) begin
              tx_nx_s    = par_r;
              state_nx_s = ST_PARITY;
            end else begin
              tx_nx_s    = 1'b1;
              state_nx_s = ST_STOP;
            end
          end else begin
            bit_nx_s = bit_cnt_r + 1'b1;
            tx_nx_s  = shift_down_s[0];
          end
        end else begin
          tx_nx_s = shift_r[0];
        end
      end

      ST_PARITY: begin
        tick_nx_s = tick_run_s;
        if (bit_end_s) begin
          tx_nx_s    = 1'b1;
          bit_nx_s   = {BW{1'b0}};
          state_nx_s = ST_STOP;
        end else begin
          tx_nx_s = par_r;
        end
      end

      ST_STOP: begin
        tick_nx_s = tick_run_s;
        tx_nx_s   = 1'b1;
        if (bit_end_s) begin
          if (bit_cnt_r == STOP_LAST) begin
            // Frame complete: drop busy and pulse done on the same edge.
            bit_nx_s   = {BW{1'b0}};
            busy_nx_s  = 1'b0;
            done_nx_s  = 1'b1;
            state_nx_s = ST_IDLE;
          end else begin
            bit_nx_s = bit_cnt_r + 1'b1;
          end
        end else begin
          bit_nx_s = bit_cnt_r;
        end
      end

      default: begin
        // Unreachable encodings recover to an idle, high line.
        tick_nx_s  = {TW{1'b0}};
        bit_nx_s   = {BW{1'b0}};
        tx_nx_s    = 1'b1;
        busy_nx_s  = 1'b0;
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset forces an idle-high line at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      tick_cnt_r <= {TW{1'b0}};
      bit_cnt_r  <= {BW{1'b0}};
      shift_r    <= {DATA_WIDTH{1'b0}};
      par_r      <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      tick_cnt_r <= tick_nx_s;
      bit_cnt_r  <= bit_nx_s;
      shift_r    <= shift_nx_s;
      par_r      <= par_nx_s;
      tx_r       <= tx_nx_s;
      busy_r     <= busy_nx_s;
      done_r     <= done_nx_s;
    end
  end

  assign bus.tx      = tx_r;
  assign bus.tx_busy = busy_r;
  assign bus.tx_done = done_r;

endmodule

// File: tb/tb_uart_tx_os.sv
// Bench for uart_tx_os. Three instances cover even parity / 1 stop,
// odd parity / 1 stop and no parity / 2 stop. Stimulus pushes the
// hand-computed frame (bit i = i-th bit on the line) into a queue; a
// monitor per instance measures each frame in baud ticks and compares.
`timescale 1ns/1ps
module tb_uart_tx_os;

  typedef struct {
    int          id;
    logic [15:0] bits;
    int          nbits;
    bit          b2b;
  } frame_t;

  logic       clk;
  logic       rst_n;
  logic       baud_tick;
  logic       start_v [3];
  logic [7:0] data_v  [3];
  logic       tx_a    [3];
  logic       busy_a  [3];
  logic       done_a  [3];
  frame_t     expq [$];
  int         n_total;
  int         n_pass;
  int         div;

  uart_tx_os_if #(.DATA_WIDTH(8)) if0 ();
  uart_tx_os_if #(.DATA_WIDTH(8)) if1 ();
  uart_tx_os_if #(.DATA_WIDTH(8)) if2 ();

  assign if0.start   = start_v[0];
  assign if0.data_in = data_v[0];
  assign if1.start   = start_v[1];
  assign if1.data_in = data_v[1];
  assign if2.start   = start_v[2];
  assign if2.data_in = data_v[2];
  assign tx_a[0]   = if0.tx;
  assign busy_a[0] = if0.tx_busy;
  assign done_a[0] = if0.tx_done;
  assign tx_a[1]   = if1.tx;
  assign busy_a[1] = if1.tx_busy;
  assign done_a[1] = if1.tx_done;
  assign tx_a[2]   = if2.tx;
  assign busy_a[2] = if2.tx_busy;
  assign done_a[2] = if2.tx_done;

  uart_tx_os #(.DATA_WIDTH(8), .PARITY(1), .OVERSAMPLE(16), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .bus(if0));
  uart_tx_os #(.DATA_WIDTH(8), .PARITY(2), .OVERSAMPLE(16), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .bus(if1));
  uart_tx_os #(.DATA_WIDTH(8), .PARITY(0), .OVERSAMPLE(16), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .bus(if2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // baud_tick every 4 clks, changed on the falling edge.
  initial begin
    baud_tick = 1'b0;
    div = 0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      baud_tick = (div == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic push(input int id, input logic [15:0] bits, input bit b2b);
    frame_t f;
    f.id = id;
    f.bits = bits;
    f.nbits = 11;
    f.b2b = b2b;
    expq.push_back(f);
  endtask

  // One-clk start pulse; data_in is scrambled right after the accept edge.
  task automatic send(input int id, input logic [7:0] d, input logic [15:0] bits);
    @(negedge clk); #1;
    start_v[id] = 1'b1;
    data_v[id]  = d;
    push(id, bits, 1'b0);
    @(negedge clk); #1;
    start_v[id] = 1'b0;
    data_v[id]  = ~d;
  endtask

  task automatic wait_frame(input int id);
    int seen;
    seen = 0;
    for (int i = 0; i < 2000 && seen == 0; i++) begin
      @(posedge clk); #1;
      if (done_a[id] === 1'b1) seen = 1;
    end
    chk("frame_done_timeout", seen, 1);
  endtask

  task automatic wait_busy(input int id);
    int seen;
    seen = 0;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      @(posedge clk); #1;
      if (busy_a[id] === 1'b1) seen = 1;
    end
    chk("busy_rise_timeout", seen, 1);
  endtask

  // Frame monitors, sampled 1ns after each rising edge.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    initial begin : mon
      frame_t      e;
      logic        busy_q;
      logic        in_frame;
      logic        have_e;
      logic        drop_chk;
      logic [15:0] first_b;
      logic [15:0] last_b;
      int          cnt;
      int          cyc;
      int          done_cyc;
      int          done_bad;
      int          k;
      int          r;
      busy_q = 1'b0; in_frame = 1'b0; have_e = 1'b0; drop_chk = 1'b0;
      first_b = 16'h0; last_b = 16'h0;
      cnt = 0; cyc = 0; done_cyc = -100; done_bad = 0; k = 0; r = 0;
      e = '{id: 0, bits: 16'h0, nbits: 0, b2b: 1'b0};
      forever begin
        @(posedge clk); #1;
        cyc++;
        if (!rst_n) begin
          in_frame = 1'b0;
          busy_q   = 1'b0;
          drop_chk = 1'b0;
        end else begin
          if (drop_chk) begin
            chk($sformatf("done_width[%0d]", g), done_a[g], 1'b0);
            drop_chk = 1'b0;
          end
          if (!busy_q && busy_a[g]) begin
            have_e = (expq.size() > 0) && (expq[0].id == g);
            chk($sformatf("frame_expected[%0d]", g), have_e, 1'b1);
            if (have_e) e = expq.pop_front();
            if (have_e && e.b2b) chk($sformatf("b2b_gap[%0d]", g), cyc - done_cyc, 1);
            in_frame = 1'b1;
            cnt = 0;
            first_b = 16'h0;
            last_b = 16'h0;
            first_b[0] = tx_a[g];
            done_bad = 0;
          end else if (busy_q && in_frame) begin
            if (baud_tick) begin
              cnt++;
              k = cnt / 16;
              r = cnt % 16;
              if (k < e.nbits && r == 0)  first_b[k] = tx_a[g];
              if (k < e.nbits && r == 15) last_b[k]  = tx_a[g];
            end
            if (busy_a[g]) begin
              if (done_a[g]) done_bad++;
            end else begin
              if (have_e) begin
                chk($sformatf("bits_first[%0d]", g), first_b, e.bits);
                chk($sformatf("bits_last[%0d]", g), last_b, e.bits);
                chk($sformatf("busy_ticks[%0d]", g), cnt, e.nbits * 16);
                chk($sformatf("done_at_end[%0d]", g), done_a[g], 1'b1);
                chk($sformatf("done_early[%0d]", g), done_bad, 0);
                chk($sformatf("tx_idle_after[%0d]", g), tx_a[g], 1'b1);
              end
              done_cyc = cyc;
              drop_chk = 1'b1;
              in_frame = 1'b0;
            end
          end
          busy_q = busy_a[g];
        end
      end
    end
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      data_v[i]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_tx",   tx_a[i],   1'b1);
      chk("reset_busy", busy_a[i], 1'b0);
      chk("reset_done", done_a[i], 1'b0);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Even parity 0xA5: start 0, data 1010_0101 LSB first, parity 0, stop 1.
    send(0, 8'hA5, 16'h054A); wait_frame(0);
    // Odd parity 0x01 -> parity 0.
    send(1, 8'h01, 16'h0402); wait_frame(1);
    // Even parity 0x01 -> parity 1.
    send(0, 8'h01, 16'h0602); wait_frame(0);
    // Odd parity 0x00 -> parity 1.
    send(1, 8'h00, 16'h0600); wait_frame(1);
    // No parity, two stop bits, 0x3C.
    send(2, 8'h3C, 16'h0678); wait_frame(2);

    // Handshake: 0x11, a mid-frame 0x22 pulse that must be ignored,
    // then 0x33 held high so it is taken one clk after tx_done.
    send(0, 8'h11, 16'h0422);
    repeat (200) @(negedge clk); #1;
    start_v[0] = 1'b1; data_v[0] = 8'h22;
    @(negedge clk); #1;
    start_v[0] = 1'b0; data_v[0] = 8'h00;
    repeat (200) @(negedge clk); #1;
    start_v[0] = 1'b1; data_v[0] = 8'h33;
    push(0, 16'h0466, 1'b1);
    wait_frame(0);
    wait_busy(0);
    @(negedge clk); #1;
    start_v[0] = 1'b0; data_v[0] = 8'hFF;
    wait_frame(0);

    // Reset mid-frame, during data bit 4 of 0x00 (line low).
    send(0, 8'h00, 16'h0400);
    repeat (350) @(posedge clk);
    #3;
    chk("pre_reset_tx",   tx_a[0],   1'b0);
    chk("pre_reset_busy", busy_a[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_tx",   tx_a[0],   1'b1);
    chk("async_reset_busy", busy_a[0], 1'b0);
    chk("async_reset_done", done_a[0], 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send(0, 8'h5A, 16'h04B4); wait_frame(0);

    // Start coincident with a baud_tick: start bit must still be 16 ticks.
    do begin
      @(negedge clk); #1;
    end while (baud_tick !== 1'b1);
    start_v[0] = 1'b1; data_v[0] = 8'hC3;
    push(0, 16'h0586, 1'b0);
    @(negedge clk); #1;
    start_v[0] = 1'b0; data_v[0] = 8'h00;
    wait_frame(0);

    repeat (10) @(negedge clk);
    chk("queue_empty", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_os.md
Name: uart_tx_os

Overview:
Oversampled UART transmitter that serialises one DATA_WIDTH word per request into a start/data/parity/stop frame. It is clocked by the shared 16x baud_tick generator, and its frame format matches the team's parity-capable oversampled UART receiver. It is driven by the TX FIFO control logic through a start/tx_busy handshake and adds a one-cycle tx_done pulse for that logic to use.

Parameters:
- DATA_WIDTH, 8: data bits per frame, transmitted LSB first.
- PARITY, 1: 0 = none, 1 = even, 2 = odd.
- OVERSAMPLE, 16: baud_tick pulses per bit period; must be >= 2.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- baud_tick  input  1  one-clk pulse at BAUD_RATE*OVERSAMPLE.
- start  input  1  transmit request; level-sampled while idle.
- data_in  input  DATA_WIDTH  word to send; sampled on accept.
- tx  output  1  serial line; idle high.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-clk pulse when the final stop bit completes.

Behaviour:
- Reset (async, rst_n=0) takes effect immediately, including mid-frame:
  - tx=1, tx_busy=0, tx_done=0.
  - State=IDLE; tick counter, bit counter and shift register cleared.
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE:
  - tx=1, tx_busy=0.
  - Accept on any clk edge with start=1: latch data_in into the shift register, compute the parity bit, clear the tick counter, go to START.
  - On the accept edge tx<=0 and tx_busy<=1, so both change one cycle after start is seen.
- Tick counter:
  - Width clog2(OVERSAMPLE). It increments only on baud_tick.
  - A bit ends on the baud_tick where counter==OVERSAMPLE-1; the counter wraps to 0 on that edge.
  - A baud_tick coincident with the accept edge is not counted.
- START: tx=0 for OVERSAMPLE ticks, then go to DATA.
- DATA:
  - tx = shift_reg[0]; shift right at each bit end.
  - After DATA_WIDTH bits, go to PARITY (PARITY!=0) or to STOP (PARITY=0).
- PARITY:
  - tx = XOR of the latched data (even), or its inverse (odd).
  - Lasts OVERSAMPLE ticks, then go to STOP.
- STOP:
  - tx=1 for STOP_BITS*OVERSAMPLE ticks.
  - On the final tick edge: state<=IDLE, tx_busy<=0, tx_done<=1 for exactly one cycle.
- Frame length: (1 + DATA_WIDTH + (PARITY!=0) + STOP_BITS) * OVERSAMPLE ticks, measured from accept.
- start while tx_busy=1: ignored. It is neither queued nor allowed to alter data in flight.
- data_in changes after accept: no effect on the current frame.
- Back-to-back frames: if start is held high, the next accept occurs on the edge after tx_done. Minimum one clk of idle-high between frames. tx stays high through that idle clk.
- No baud_tick: the state machine holds its current bit indefinitely with tx stable.

Test Plan:
All cases use OVERSAMPLE=16, baud_tick every 4 clks, DATA_WIDTH=8.

1. Even-parity frame.
   - Stimulus: PARITY=1, STOP_BITS=1, one-clk start with data_in=0xA5.
   - Required: tx sequence 0,1,0,1,0,0,1,0,1,0(parity),1(stop), each bit 16 ticks.
   - Required: tx_busy high 176 ticks; tx_done is a single pulse as tx_busy falls.
2. Odd parity.
   - Stimulus: PARITY=2, data_in=0x01.
   - Required: parity bit 0.
   - Stimulus: rerun with PARITY=1.
   - Required: parity bit 1.
   - Stimulus: PARITY=2, data_in=0x00.
   - Required: parity bit 1.
3. No parity, two stop bits.
   - Stimulus: PARITY=0, STOP_BITS=2, data_in=0x3C.
   - Required: 0,0,0,1,1,1,1,0,0 then stop high 32 ticks; frame 176 ticks; no parity slot.
4. Handshake.
   - Stimulus: assert start with data 0x11, then pulse start with 0x22 mid-frame, then hold start high with 0x33 after the first frame.
   - Required: 0x22 is never sent.
   - Required: 0x33 is accepted exactly one clk after tx_done, with tx high during that clk.
5. Reset mid-frame.
   - Stimulus: drop rst_n during data bit 4.
   - Required: tx=1, tx_busy=0, tx_done=0 asynchronously.
   - Stimulus: after release, start with 0x5A.
   - Required: clean full-length frame.
6. Tick/accept coincidence.
   - Stimulus: assert start on the same clk as a baud_tick.
   - Required: start bit spans 16 subsequent ticks, not 15.
